// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential divider.
package seq_div_pkg;

  // One state encoding used by both the controller and the datapath
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPERATE = 2'd1,
    DONE    = 2'd2
  } div_state_t;

  localparam int XLEN_DEFAULT = 16;

  // Width of the step counter; it counts XLEN-1 down to 0
  function automatic int cnt_width(input int xlen);
    return $clog2(xlen);
  endfunction

endpackage

// File: rtl/seq_div_if.sv
// Operand and result handshake bundle for the sequential divider.
interface seq_div_if #(
  parameter int XLEN = 16
) ();

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;
  logic            div_by_zero;

  // Producer of operands and consumer of results
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  // The divider itself
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_div_datapath.sv
// Restoring shift-subtract datapath: quotient/remainder/divisor registers,
// step counter and the one trial subtractor.
module seq_div_datapath
  import seq_div_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  div_state_t      state,
  input  logic            load,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] q,
  output logic [XLEN-1:0] r,
  output logic            dbz,
  output logic            count_zero
);

  localparam int CNT_W = cnt_width(XLEN);

  logic [XLEN-1:0]  q_reg;
  logic [XLEN-1:0]  r_reg;
  logic [XLEN-1:0]  d_reg;
  logic [CNT_W-1:0] count;
  logic             dbz_reg;
  logic [XLEN:0]    rs;
  logic [XLEN:0]    trial;
  logic             q_bit;

  // Trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    rs    = {r_reg, q_reg[XLEN-1]};
    trial = rs - {1'b0, d_reg};
    q_bit = ~trial[XLEN];
  end

  // Load operands on accept (divide-by-zero result is set immediately), then one step per OPERATE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg   <= '0;
      r_reg   <= '0;
      d_reg   <= '0;
      count   <= '0;
      dbz_reg <= 1'b0;
    end else if (load) begin
      d_reg <= divisor;
      count <= CNT_W'(XLEN - 1);
      if (divisor == '0) begin
        q_reg   <= '1;
        r_reg   <= dividend;
        dbz_reg <= 1'b1;
      end else begin
        q_reg   <= dividend;
        r_reg   <= '0;
        dbz_reg <= 1'b0;
      end
    end else if (state == OPERATE) begin
      r_reg <= q_bit ? trial[XLEN-1:0] : rs[XLEN-1:0];
      q_reg <= {q_reg[XLEN-2:0], q_bit};
      count <= count - CNT_W'(1);
    end
  end

  assign q          = q_reg;
  assign r          = r_reg;
  assign dbz        = dbz_reg;
  assign count_zero = (count == '0);

endmodule

// File: rtl/seq_div.sv
// Unsigned sequential divider, one quotient bit per cycle, with valid/ready
// handshakes on operands and results.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic     clk,
  input  logic     reset,
  seq_div_if.slave bus
);

  div_state_t      state;
  div_state_t      state_nxt;
  logic            load;
  logic            in_ready;
  logic            out_valid;
  logic            count_zero;
  logic [XLEN-1:0] q;
  logic [XLEN-1:0] r;
  logic            dbz;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: divide-by-zero skips the stepping phase entirely
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = (bus.divisor == '0) ? DONE : OPERATE;
      OPERATE: if (count_zero)   state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs and the load strobe for the datapath
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    load      = in_ready && bus.in_valid;
  end

  seq_div_datapath #(.XLEN(XLEN)) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .state      (state),
    .load       (load),
    .dividend   (bus.dividend),
    .divisor    (bus.divisor),
    .q          (q),
    .r          (r),
    .dbz        (dbz),
    .count_zero (count_zero)
  );

  // Results are forced to zero whenever they are not valid
  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.quotient    = out_valid ? q : '0;
  assign bus.remainder   = out_valid ? r : '0;
  assign bus.div_by_zero = out_valid & dbz;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (XLEN=16) against an arithmetic reference.
module tb_seq_div;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  seq_div_if #(.XLEN(16)) bus ();

  seq_div #(.XLEN(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain / and %, with the divide-by-zero convention
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic dbz, output int lat);
    if (b == 16'd0) begin
      q = 16'hFFFF; r = a; dbz = 1'b1; lat = 1;
    end else begin
      q = a / b; r = a % b; dbz = 1'b0; lat = 17;
    end
  endtask

  // Wait for in_ready, offer operands for one cycle, wait for out_valid, hold, then accept
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input int pre_gap, input int hold,
                        output logic [15:0] q, output logic [15:0] r,
                        output logic dbz, output int lat, output bit ok);
    int guard;
    ok = 1'b1;
    repeat (pre_gap) begin @(posedge clk); #1; end
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 50) ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 16'($urandom);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (bus.out_valid !== 1'b1) ok = 1'b0;
    q   = bus.quotient;
    r   = bus.remainder;
    dbz = bus.div_by_zero;
    repeat (hold) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_handshake: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
    end
    n_vec++;
    if (bus.quotient !== 16'd0 || bus.remainder !== 16'd0 || bus.div_by_zero !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got q=%h r=%h dbz=%b expected 0/0/0", bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask

  // Known vectors including divide-by-zero and the boundary operands
  task automatic test_directed();
    logic [15:0] a_tab [6] = '{16'd100, 16'h1234, 16'hFFFF, 16'd5, 16'hFFFF, 16'd1000};
    logic [15:0] b_tab [6] = '{16'd7,   16'd0,    16'd1,    16'd9, 16'hFFFF, 16'd3};
    logic [15:0] qe_tab[6] = '{16'd14,  16'hFFFF, 16'hFFFF, 16'd0, 16'd1,    16'd333};
    logic [15:0] re_tab[6] = '{16'd2,   16'h1234, 16'd0,    16'd5, 16'd0,    16'd1};
    logic [15:0] q, r;
    logic dbz;
    int lat, lat_e;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      run_op(a_tab[i], b_tab[i], 0, 0, q, r, dbz, lat, ok);
      lat_e = (b_tab[i] == 16'd0) ? 1 : 17;
      n_vec++;
      if (!ok || q !== qe_tab[i] || r !== re_tab[i] || dbz !== (b_tab[i] == 16'd0)) begin
        n_err++;
        $display("[TB] FAIL directed_%0d: got q=%h r=%h dbz=%b ok=%0d expected q=%h r=%h dbz=%b",
                 i, q, r, dbz, ok, qe_tab[i], re_tab[i], b_tab[i] == 16'd0);
      end
      n_vec++;
      if (lat !== lat_e) begin
        n_err++;
        $display("[TB] FAIL latency_%0d: got %0d expected %0d", i, lat, lat_e);
      end
    end
  endtask

  // Result held under backpressure while a stray in_valid is ignored
  task automatic test_backpressure();
    logic [15:0] q0, r0;
    int guard;
    bus.in_valid = 1'b1; bus.dividend = 16'd100; bus.divisor = 16'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    guard = 0;
    while (bus.out_valid !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
    n_vec++;
    if (bus.out_valid !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL bp_done_timeout: got out_valid=%b expected 1", bus.out_valid);
    end
    q0 = bus.quotient; r0 = bus.remainder;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 2); bus.dividend = 16'd50; bus.divisor = 16'd5;
      @(posedge clk); #1;
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || q0 !== 16'd14 || r0 !== 16'd2 ||
          bus.quotient !== q0 || bus.remainder !== r0) begin
        n_err++;
        $display("[TB] FAIL bp_hold_%0d: got ov=%b ir=%b q=%h r=%h expected ov=1 ir=0 q=000e r=0002",
                 i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.quotient !== 16'd0) begin
      n_err++;
      $display("[TB] FAIL bp_release: got ov=%b ir=%b q=%h expected ov=0 ir=1 q=0000",
               bus.out_valid, bus.in_ready, bus.quotient);
    end
  endtask

  // Reset partway through a division, then the same division from scratch
  task automatic test_reset_mid_op();
    logic [15:0] q, r;
    logic dbz;
    int lat;
    bit ok;
    bus.in_valid = 1'b1; bus.dividend = 16'd1000; bus.divisor = 16'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.remainder !== 16'd0) begin
      n_err++;
      $display("[TB] FAIL reset_abort: got ov=%b ir=%b r=%h expected ov=0 ir=1 r=0000",
               bus.out_valid, bus.in_ready, bus.remainder);
    end
    run_op(16'd1000, 16'd3, 0, 0, q, r, dbz, lat, ok);
    n_vec++;
    if (!ok || q !== 16'd333 || r !== 16'd1 || dbz !== 1'b0 || lat !== 17) begin
      n_err++;
      $display("[TB] FAIL reset_rerun: got q=%0d r=%0d dbz=%b lat=%0d expected q=333 r=1 dbz=0 lat=17",
               q, r, dbz, lat);
    end
  endtask

  // Random operands and random handshake gaps against the reference
  task automatic test_random();
    logic [15:0] a, b, q, r, qe, re;
    logic dbz, dbze;
    int lat, late;
    bit ok;
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'd0;
        1, 2:    b = 16'($urandom_range(1, 15));
        3:       b = a;
        default: b = 16'($urandom);
      endcase
      model(a, b, qe, re, dbze, late);
      run_op(a, b, $urandom_range(0, 3), $urandom_range(0, 3), q, r, dbz, lat, ok);
      n_vec++;
      if (!ok || q !== qe || r !== re || dbz !== dbze) begin
        n_err++;
        $display("[TB] FAIL random_%0d %h/%h: got q=%h r=%h dbz=%b expected q=%h r=%h dbz=%b",
                 i, a, b, q, r, dbz, qe, re, dbze);
      end
      n_vec++;
      if (lat !== late) begin
        n_err++;
        $display("[TB] FAIL random_latency_%0d: got %0d expected %0d", i, lat, late);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = 16'd0;
    bus.divisor   = 16'd0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
